// File: rtl/queue_table_cfg_ctrl.sv
// queue_table_cfg_ctrl: zero-sweeps the four per-queue tables, then serialises config reads/writes into single BRAM accesses.
module queue_table_cfg_ctrl #(
  parameter int NB_QUEUES  = 4,
  parameter int RB_AWIDTH  = 16,
  parameter int RD_LATENCY = 2,
  parameter int QAW        = $clog2(NB_QUEUES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RB_AWIDTH:0]   rb_size,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_wr,
  input  logic [1:0]           cfg_field,
  input  logic [QAW-1:0]       cfg_queue_id,
  input  logic [31:0]          cfg_wr_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [QAW-1:0]       bram_addr,
  output logic [31:0]          bram_wr_data,
  output logic [3:0]           bram_wr_en,
  output logic [3:0]           bram_rd_en,
  input  logic [127:0]         bram_rd_data,
  output logic                 init_done,
  output logic [31:0]          bad_cfg_cnt
);
  localparam int CW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RSP} state_t;
  state_t state, state_nxt;
  logic [QAW-1:0] ptr, addr_nxt;
  logic [CW-1:0] cnt;
  logic [1:0] field;
  logic [31:0] wr_data_nxt;
  logic [3:0] sel, wr_en_nxt, rd_en_nxt;
  logic accept, bad_head, capture;
  assign cfg_ready = state == IDLE;
  assign accept = cfg_valid & cfg_ready;
  assign sel = 4'b1 << cfg_field;
  assign bad_head = cfg_field == 2'd1 && cfg_wr_data >= 32'(rb_size);
  assign capture = state == RD_WAIT && state_nxt == RSP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = ptr == QAW'(NB_QUEUES - 1) ? IDLE : INIT;
      IDLE:    state_nxt = accept && !cfg_wr ? RD_WAIT : IDLE;
      RD_WAIT: state_nxt = cnt == CW'(RD_LATENCY - 1) ? RSP : RD_WAIT;
      RSP:     state_nxt = rsp_ready ? IDLE : RSP;
    endcase
  end
  always_comb begin
    addr_nxt    = state == INIT ? ptr : accept ? cfg_queue_id : bram_addr;
    wr_data_nxt = state == INIT ? '0 : accept && cfg_wr ? cfg_wr_data : bram_wr_data;
    wr_en_nxt   = state == INIT ? 4'hf : accept && cfg_wr && !bad_head ? sel : 4'h0;
    rd_en_nxt   = accept && !cfg_wr ? sel : 4'h0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr          <= '0;
      cnt          <= '0;
      field        <= '0;
      bram_addr    <= '0;
      bram_wr_data <= '0;
      bram_wr_en   <= '0;
      bram_rd_en   <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      init_done    <= 1'b0;
      bad_cfg_cnt  <= '0;
    end else begin
      ptr          <= state == INIT ? ptr + 1'b1 : '0;
      cnt          <= state == RD_WAIT ? cnt + 1'b1 : '0;
      field        <= accept ? cfg_field : field;
      bram_addr    <= addr_nxt;
      bram_wr_data <= wr_data_nxt;
      bram_wr_en   <= wr_en_nxt;
      bram_rd_en   <= rd_en_nxt;
      init_done    <= init_done | (state == INIT && state_nxt == IDLE);
      // rejected head writes are still consumed; only the counter records them
      bad_cfg_cnt  <= accept && cfg_wr && bad_head && bad_cfg_cnt != '1 ? bad_cfg_cnt + 1'b1 : bad_cfg_cnt;
      rsp_valid    <= capture ? 1'b1 : state == RSP && rsp_ready ? 1'b0 : rsp_valid;
      rsp_data     <= capture ? bram_rd_data[{field, 5'd0} +: 32] : rsp_data;
    end
endmodule

// File: tb/tb_queue_table_cfg_ctrl.sv
// tb_queue_table_cfg_ctrl: directed plan plus randomized traffic, checked every cycle against a transaction-level model.
module tb_queue_table_cfg_ctrl;
  localparam int NB = 4;
  localparam int QAW = 2;
  logic clk = 0, rst_n;
  logic [16:0] rb_size;
  logic cfg_valid, cfg_ready, cfg_wr, rsp_valid, rsp_ready, init_done;
  logic [1:0] cfg_field;
  logic [QAW-1:0] cfg_queue_id, bram_addr;
  logic [31:0] cfg_wr_data, rsp_data, bram_wr_data, bad_cfg_cnt;
  logic [3:0] bram_wr_en, bram_rd_en;
  logic [127:0] bram_rd_data;
  int errors = 0, checks = 0;

  queue_table_cfg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rb_size(rb_size),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_wr(cfg_wr), .cfg_field(cfg_field),
    .cfg_queue_id(cfg_queue_id), .cfg_wr_data(cfg_wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .bram_addr(bram_addr), .bram_wr_data(bram_wr_data), .bram_wr_en(bram_wr_en),
    .bram_rd_en(bram_rd_en), .bram_rd_data(bram_rd_data),
    .init_done(init_done), .bad_cfg_cnt(bad_cfg_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM stand-in: data of a read is presented for exactly one cycle, garbage otherwise
  logic [31:0] mem [4][NB];
  always @(posedge clk) begin
    bram_rd_data <= bram_rd_en != 0 ? {mem[3][bram_addr], mem[2][bram_addr], mem[1][bram_addr], mem[0][bram_addr]}
                                    : {$urandom, $urandom, $urandom, $urandom};
    for (int f = 0; f < 4; f++) if (bram_wr_en[f]) mem[f][bram_addr] <= bram_wr_data;
  end

  // transaction-level reference: what each cycle's outputs must be
  logic [31:0] ref_mem [4][NB];
  int sweep, rd_left;
  logic m_ready, m_done, m_rsp_v, cur_ready;
  logic [31:0] m_bad, m_rsp_d, e_data;
  logic [3:0] e_wr, e_rd;
  logic [QAW-1:0] e_addr;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_zero", 64'(|{cfg_ready, rsp_valid, rsp_data, bram_addr, bram_wr_data, bram_wr_en, bram_rd_en, init_done, bad_cfg_cnt}), 64'd0);
      sweep = 0; rd_left = 0; m_ready = 0; m_done = 0; m_rsp_v = 0; m_rsp_d = 0; m_bad = 0;
      e_wr = 0; e_rd = 0; e_addr = 0; e_data = 0;
      for (int f = 0; f < 4; f++) for (int q = 0; q < NB; q++) ref_mem[f][q] = 0;
    end else begin
      chk("cfg_ready", 64'(cfg_ready), 64'(m_ready));
      chk("init_done", 64'(init_done), 64'(m_done));
      chk("bad_cfg_cnt", 64'(bad_cfg_cnt), 64'(m_bad));
      chk("wr_en", 64'(bram_wr_en), 64'(e_wr));
      chk("rd_en", 64'(bram_rd_en), 64'(e_rd));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
      if (e_wr != 0 || e_rd != 0) chk("bram_addr", 64'(bram_addr), 64'(e_addr));
      if (e_wr != 0) chk("bram_wr_data", 64'(bram_wr_data), 64'(e_data));
      if (m_rsp_v) chk("rsp_data", 64'(rsp_data), 64'(m_rsp_d));
      cur_ready = m_ready;
      e_wr = 0; e_rd = 0;
      if (m_rsp_v && rsp_ready) begin m_rsp_v = 0; m_ready = 1; end
      if (rd_left > 0) begin rd_left--; if (rd_left == 0) m_rsp_v = 1; end
      if (sweep < NB) begin
        e_wr = 4'hf; e_addr = QAW'(sweep); e_data = 0; sweep++;
        if (sweep == NB) begin m_ready = 1; m_done = 1; end
      end else if (cur_ready && cfg_valid) begin
        e_addr = cfg_queue_id;
        if (!cfg_wr) begin
          e_rd = 4'b1 << cfg_field; m_ready = 0; rd_left = 2; m_rsp_d = ref_mem[cfg_field][cfg_queue_id];
        end else if (cfg_field == 1 && cfg_wr_data >= 32'(rb_size)) begin
          if (m_bad != 32'hffff_ffff) m_bad++;
        end else begin
          e_wr = 4'b1 << cfg_field; e_data = cfg_wr_data; ref_mem[cfg_field][cfg_queue_id] = cfg_wr_data;
        end
      end
    end
  end

  task automatic do_cfg(input logic wr, input logic [1:0] f, input logic [QAW-1:0] q, input logic [31:0] d);
    logic ok = 0;
    cfg_valid = 1; cfg_wr = wr; cfg_field = f; cfg_queue_id = q; cfg_wr_data = d;
    for (int n = 0; n < 50 && !ok; n++) begin @(negedge clk); ok = cfg_ready; end
    chk("cfg_accept", 64'(ok), 64'd1);
    @(posedge clk); #1 cfg_valid = 0;
  endtask

  task automatic do_read(input logic [1:0] f, input logic [QAW-1:0] q, output logic [31:0] d, output int lat);
    d = 0; lat = -1;
    do_cfg(0, f, q, 0);
    chk("rd_pulse", 64'(bram_rd_en), 64'(4'b1 << f));
    chk("rd_addr", 64'(bram_addr), 64'(q));
    for (int n = 0; n < 20 && lat < 0; n++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = n + 1; d = rsp_data; end
    end
    chk("rsp_latency", 64'(lat), 64'd3);
    @(posedge clk); #1;
  endtask

  task automatic sweep_check();
    int n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bram_wr_en == 4'hf) n++;
      if (i == 3) chk("init_done_early", 64'(init_done), 64'd0);
      if (i == 4) chk("init_done_5th", 64'(init_done), 64'd1);
    end
    chk("sweep_len", 64'(n), 64'd4);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000 $display("FAIL watchdog expired"); $fatal(1);
  end

  initial begin
    logic [31:0] d, rbz;
    int lat;
    rst_n = 1; cfg_valid = 0; cfg_wr = 0; cfg_field = 0; cfg_queue_id = 0; cfg_wr_data = 0;
    rsp_ready = 1; rb_size = 17'd64;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    sweep_check();
    do_cfg(1, 2, 1, 32'h0001_0000);
    chk("t2_wr_en", 64'(bram_wr_en), 64'h4);
    chk("t2_addr", 64'(bram_addr), 64'd1);
    chk("t2_data", 64'(bram_wr_data), 64'h1_0000);
    do_read(2, 1, d, lat);
    chk("t2_rdata", 64'(d), 64'h1_0000);
    do_cfg(1, 1, 0, 32'd63);
    chk("t3_wr_en", 64'(bram_wr_en), 64'h2);
    chk("t3_data", 64'(bram_wr_data), 64'd63);
    do_cfg(1, 1, 0, 32'd64);
    chk("t3_rejected", 64'(bram_wr_en), 64'd0);
    chk("t3_bad_cnt", 64'(bad_cfg_cnt), 64'd1);
    do_read(1, 0, d, lat);
    chk("t3_rdata", 64'(d), 64'd63);
    rsp_ready = 0;
    do_cfg(0, 2, 1, 0);
    cfg_valid = 1; cfg_wr = 1; cfg_field = 0; cfg_queue_id = 2; cfg_wr_data = 32'h55;
    lat = -1;
    for (int n = 0; n < 20 && lat < 0; n++) begin @(negedge clk); if (rsp_valid) lat = n; end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t4_hold_data", 64'(rsp_data), 64'h1_0000);
      chk("t4_ready_low", 64'(cfg_ready), 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk); chk("t4_ready_hs", 64'(cfg_ready), 64'd0);
    @(negedge clk); chk("t4_ready_back", 64'(cfg_ready), 64'd1);
    @(posedge clk); #1 cfg_valid = 0;
    chk("t4_wr_en", 64'(bram_wr_en), 64'h1);
    chk("t4_wr_data", 64'(bram_wr_data), 64'h55);
    for (int i = 0; i < 4; i++) begin
      do_cfg(1, 2'(i), 3, 32'hA + 32'(i));
      chk("t5_wr_en", 64'(bram_wr_en), 64'(4'b1 << i));
      chk("t5_data", 64'(bram_wr_data), 64'hA + 64'(i));
    end
    do_cfg(0, 0, 2, 0);
    rst_n = 0;
    #1 chk("t6_async_zero", 64'(|{cfg_ready, rsp_valid, rsp_data, bram_addr, bram_wr_data, bram_wr_en, bram_rd_en, init_done, bad_cfg_cnt}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    sweep_check();
    for (int c = 0; c < 3000; c++) begin
      int unsigned k;
      if (c % 500 == 0) rb_size = 17'($urandom_range(1, 131071));
      rbz = 32'(rb_size);
      k = $urandom % 4;
      cfg_valid = ($urandom % 3) != 0;
      cfg_wr = 1'($urandom);
      cfg_field = 2'($urandom);
      cfg_queue_id = QAW'($urandom_range(0, NB - 1));
      cfg_wr_data = cfg_field != 1 ? $urandom : k == 0 ? rbz - 1 : k == 1 ? rbz : k == 2 ? $urandom_range(0, rbz + 3) : $urandom;
      rsp_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    cfg_valid = 0; rsp_ready = 1;
    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/queue_table_cfg_ctrl.md
Name: queue_table_cfg_ctrl

Overview:
Sequences all software-side accesses to the four per-queue BRAM tables (tails, heads, l_addrs, h_addrs) that the queue manager reads on its user side.
- After reset, sweeps every queue entry to zero.
- Then serialises config reads and writes (from the PCIe register path) into single BRAM accesses.
- Returns read data through a valid/ready response channel and rejects illegal head values.

Parameters:
NB_QUEUES, 4, number of queues; must be a power of 2 and at least 2.
RB_AWIDTH, 16, ring-buffer address width; rb_size is RB_AWIDTH+1 bits.
RD_LATENCY, 2, BRAM read latency in cycles from rd_en to valid rd_data.
QAW, $clog2(NB_QUEUES), derived queue-id width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rb_size  in  RB_AWIDTH+1  ring-buffer size in flits; head write legal iff value < rb_size
cfg_valid  in  1  config request valid
cfg_ready  out  1  config request accepted when valid&ready
cfg_wr  in  1  1=write, 0=read
cfg_field  in  2  0=tail, 1=head, 2=l_addr, 3=h_addr
cfg_queue_id  in  QAW  target queue
cfg_wr_data  in  32  write data
rsp_valid  out  1  read response valid
rsp_ready  in  1  read response consumed when valid&ready
rsp_data  out  32  read data
bram_addr  out  QAW  shared address to all four tables
bram_wr_data  out  32  shared write data
bram_wr_en  out  4  per-table write enable, bit index = field
bram_rd_en  out  4  per-table read enable, bit index = field
bram_rd_data  in  4x32  per-table read data; field f on bits [32f+31:32f]
init_done  out  1  high once the init sweep completes
bad_cfg_cnt  out  32  count of rejected head writes

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=INIT, sweep pointer=0.
  - All outputs 0: cfg_ready, rsp_valid, rsp_data, bram_*, init_done, bad_cfg_cnt.
  - Reset mid-operation aborts any pending read (no response issued) and restarts the sweep.
- All bram_* outputs are registered; every enable is a single-cycle pulse.
- cfg_ready is 1 only in IDLE and is combinational from state.
- States:
  - INIT: each cycle, bram_wr_en=4'b1111, bram_addr=pointer, bram_wr_data=0, pointer++. After the write to NB_QUEUES-1, go to IDLE. init_done goes 1 on the IDLE entry cycle and stays 1 until reset. INIT lasts exactly NB_QUEUES cycles; cfg_valid is ignored throughout.
  - IDLE, write accepted: next cycle drives bram_addr=cfg_queue_id, bram_wr_data=cfg_wr_data, bram_wr_en=1<<cfg_field. Stays in IDLE, so back-to-back writes sustain 1 per cycle.
  - IDLE, head write with cfg_wr_data >= rb_size (unsigned, zero-extended compare): request is still accepted, no wr_en is asserted, bad_cfg_cnt increments (saturates at 2^32-1). Tail, l_addr and h_addr writes are never range-checked.
  - IDLE, read accepted: next cycle drives bram_addr=cfg_queue_id, bram_rd_en=1<<cfg_field. Field is latched; go to RD_WAIT.
  - RD_WAIT: counts RD_LATENCY cycles after the rd_en cycle. On the last count, capture bram_rd_data slice [field] into rsp_data, set rsp_valid=1, go to RSP.
  - RSP: hold rsp_valid and rsp_data stable until rsp_ready. On handshake, rsp_valid=0 next cycle and state returns to IDLE. cfg_ready=0 throughout RD_WAIT and RSP, so only one read is outstanding at a time.
- Read latency: cfg accept at cycle T gives rsp_valid at T+1+RD_LATENCY.
- A write issued the cycle after a read's rsp handshake is legal. Write-then-read of the same entry returns the new value, since write and read never overlap in the BRAM.

Test Plan:
1. Reset released, NB_QUEUES=4 -> wr_en=1111 for exactly 4 cycles at addr 0,1,2,3 with data 0; init_done=1 on the 5th cycle; cfg_ready=0 throughout the sweep.
2. Write field 2, queue 1, data 0x00010000; then read it back -> wr_en=0100 at addr 1; rd_en=0100 one cycle after read accept; rsp_valid exactly 3 cycles after accept with rsp_data=0x00010000.
3. rb_size=64: head write 63 to queue 0, then head write 64 -> first gives wr_en=0010 with data 63; second gives no wr_en and bad_cfg_cnt=1; a subsequent head read returns 63.
4. Read response with rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable for all 5 cycles, cfg_ready=0; a cfg_valid write arriving meanwhile is accepted only after the handshake.
5. Four back-to-back writes (fields 0..3, queue 3, data 0xA..0xD) -> four consecutive cycles with wr_en 0001, 0010, 0100, 1000 and matching data; cfg_ready never drops.
6. Assert rst_n low during RD_WAIT -> all outputs 0 immediately; no rsp_valid is ever issued for the aborted read; the full INIT sweep reruns after release.
